microseq_engine: RTL and testbench

Microcode sequencer for the bytecode-to-ARM translation path, and the consumer of the next-address ROM. It accepts one JVM bytecode opcode per transaction, uses it as the microcode entry address and drives the ROM address. It then walks the next-address chain, emitting one micro-op address per step to the downstream ARM emitter until the ROM returns 0 (end of bytecode). Illegal chain targets and runaway chains are trapped into a sticky error state.

---
 rtl/microseq_engine.sv | 85 ++++++++
 tb/tb_microseq_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_engine.sv
// Microcode sequencer: takes a JVM opcode as the entry address and walks the
// next-address ROM chain, emitting one micro-op address per handshake.
module microseq_engine #(
  parameter int MAX_STEPS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bc_valid,
  output logic        bc_ready,
  input  logic [7:0]  bc_opcode,
  output logic [8:0]  rom_addr,
  input  logic [8:0]  rom_data,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic [8:0]  uop_addr,
  output logic        uop_last,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        err_clr,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;

  localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

  state_t     state;
  logic [8:0] cur;
  logic [7:0] step_cnt;
  logic       chain_end;
  logic       bad_tgt;

  assign chain_end = (rom_data == 9'd0);
  // Targets must land in the upper half; 0x1FF is the ROM's undefined-address return.
  assign bad_tgt   = !rom_data[8] || (rom_data == 9'h1FF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      step_cnt <= '0;
      retired  <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        IDLE: if (bc_valid) begin
          cur      <= {1'b0, bc_opcode};
          step_cnt <= '0;
          state    <= EMIT;
        end
        EMIT: if (uop_ready) begin
          if (chain_end) begin
            retired <= retired + 16'd1;
            state   <= IDLE;
          end else if (bad_tgt) begin
            err_code <= 2'b01;
            state    <= ERR;
          end else if (step_cnt == LAST_STEP) begin
            err_code <= 2'b10;
            state    <= ERR;
          end else begin
            cur      <= rom_data;
            step_cnt <= step_cnt + 8'd1;
          end
        end
        ERR: if (err_clr) begin
          err_code <= 2'b00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register, so async reset drops them at once.
  assign bc_ready  = (state == IDLE);
  assign uop_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign err       = (state == ERR);
  assign rom_addr  = cur;
  assign uop_addr  = cur;
  assign uop_last  = uop_valid ? chain_end : 1'b0;

endmodule

// File: tb/tb_microseq_engine.sv
// Bench for microseq_engine: vector table, hand-written corner sequences and
// randomized chains against a ROM-walking reference model.
module tb_microseq_engine;

  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bc_valid = 1'b0;
  logic [7:0]  bc_opcode = '0;
  logic        uop_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        bc_ready, uop_valid, uop_last, busy, err;
  logic [8:0]  rom_addr, rom_data, uop_addr;
  logic [1:0]  err_code;
  logic [15:0] retired;

  logic        bc_ready2, uop_valid2, uop_last2, busy2, err2;
  logic [8:0]  rom_addr2, rom_data2, uop_addr2;
  logic [1:0]  err_code2;
  logic [15:0] retired2;

  logic [8:0]  rom_mem [512];

  assign rom_data  = rom_mem[rom_addr];
  assign rom_data2 = rom_mem[rom_addr2];

  always #5 clk = ~clk;

  microseq_engine #(.MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .bc_valid(bc_valid), .bc_ready(bc_ready),
    .bc_opcode(bc_opcode), .rom_addr(rom_addr), .rom_data(rom_data),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_addr(uop_addr),
    .uop_last(uop_last), .busy(busy), .err(err), .err_code(err_code),
    .err_clr(err_clr), .retired(retired)
  );

  microseq_engine #(.MAX_STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .bc_valid(bc_valid), .bc_ready(bc_ready2),
    .bc_opcode(bc_opcode), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .uop_valid(uop_valid2), .uop_ready(uop_ready), .uop_addr(uop_addr2),
    .uop_last(uop_last2), .busy(busy2), .err(err2), .err_code(err_code2),
    .err_clr(err_clr), .retired(retired2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        bv;
    logic [7:0]  op;
    logic        rdy;
    logic        uv;
    logic [8:0]  addr;
    logic        last;
    logic        bcr;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl [18];

  // Reference model state
  logic [8:0] exp_q [$];
  logic [1:0] exp_code;
  int         exp_ret;
  logic [8:0] obs_addr [$];
  logic       obs_last [$];
  logic       obs_err;
  logic [1:0] obs_code;

  // Walk the ROM from the entry address applying the chain rules directly.
  task automatic ref_walk(input logic [7:0] op);
    logic [8:0] a, nx;
    a = {1'b0, op};
    exp_q.delete();
    exp_code = 2'b00;
    forever begin
      exp_q.push_back(a);
      nx = rom_mem[a];
      if (nx == 9'd0) break;
      if (nx < 9'd256 || nx == 9'h1FF) begin exp_code = 2'b01; break; end
      if (exp_q.size() == MS) begin exp_code = 2'b10; break; end
      a = nx;
    end
  endtask

  // Starts in IDLE at posedge+1; returns at posedge+1 back in IDLE.
  task automatic run_txn(input logic [7:0] op, input bit bp);
    int         cyc;
    logic       prev_stall;
    logic [8:0] prev_addr;
    logic       prev_last;
    obs_addr.delete();
    obs_last.delete();
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_last  = 1'b0;
    bc_valid  = 1'b1;
    bc_opcode = op;
    uop_ready = 1'b0;
    @(posedge clk); #1;
    bc_valid = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      uop_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      err_clr   = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (!uop_valid) break;
      if (prev_stall) begin
        chk("stall_addr", uop_addr, prev_addr);
        chk("stall_last", uop_last, prev_last);
      end
      if (uop_ready) begin
        obs_addr.push_back(uop_addr);
        obs_last.push_back(uop_last);
      end
      prev_stall = !uop_ready;
      prev_addr  = uop_addr;
      prev_last  = uop_last;
      @(posedge clk); #1;
    end
    if (cyc == 300) chk("txn_timeout", 1, 0);
    obs_err   = err;
    obs_code  = err_code;
    err_clr   = 1'b0;
    uop_ready = 1'b0;
    @(posedge clk); #1;
    if (obs_err) begin
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("clr_bc_ready", bc_ready, 1);
      chk("clr_err_code", err_code, 0);
    end
  endtask

  task automatic compare_txn();
    int n;
    logic exp_last;
    chk("txn_len", obs_addr.size(), exp_q.size());
    n = (obs_addr.size() < exp_q.size()) ? obs_addr.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_last = (i == exp_q.size() - 1) && (exp_code == 2'b00);
      chk("txn_addr", obs_addr[i], exp_q[i]);
      chk("txn_last", obs_last[i], exp_last);
    end
    chk("txn_err", obs_err, exp_code != 2'b00);
    chk("txn_code", obs_code, exp_code);
    if (exp_code == 2'b00) exp_ret = (exp_ret + 1) & 16'hFFFF;
    chk("txn_retired", retired, exp_ret);
  endtask

  initial begin
    int exp_a [3];
    logic [7:0] op;
    exp_a = '{89, 256, 257};

    for (int a = 0; a < 512; a++) rom_mem[a] = 9'd0;
    rom_mem[89] = 9'd256; rom_mem[256] = 9'd257; rom_mem[257] = 9'd0;
    rom_mem[92] = 9'd258; rom_mem[258] = 9'd259; rom_mem[259] = 9'd0;

    //           bv  op     rdy uv  addr  last bcr ret
    tbl[0]  = '{1, 8'h59, 1, 0, 9'd0,   0, 1, 0};
    tbl[1]  = '{0, 8'h00, 1, 1, 9'd89,  0, 0, 0};
    tbl[2]  = '{0, 8'h00, 1, 1, 9'd256, 0, 0, 0};
    tbl[3]  = '{0, 8'h00, 1, 1, 9'd257, 1, 0, 0};
    tbl[4]  = '{1, 8'h00, 1, 0, 9'd0,   0, 1, 1};
    tbl[5]  = '{1, 8'h5C, 1, 1, 9'd0,   1, 0, 1};
    tbl[6]  = '{1, 8'h5C, 1, 0, 9'd0,   0, 1, 2};
    tbl[7]  = '{0, 8'h00, 1, 1, 9'd92,  0, 0, 2};
    tbl[8]  = '{0, 8'h00, 1, 1, 9'd258, 0, 0, 2};
    tbl[9]  = '{0, 8'h00, 1, 1, 9'd259, 1, 0, 2};
    tbl[10] = '{1, 8'h59, 1, 0, 9'd0,   0, 1, 3};
    tbl[11] = '{0, 8'h00, 1, 1, 9'd89,  0, 0, 3};
    tbl[12] = '{0, 8'h00, 0, 1, 9'd256, 0, 0, 3};
    tbl[13] = '{0, 8'h00, 0, 1, 9'd256, 0, 0, 3};
    tbl[14] = '{0, 8'h00, 1, 1, 9'd256, 0, 0, 3};
    tbl[15] = '{0, 8'h00, 0, 1, 9'd257, 1, 0, 3};
    tbl[16] = '{0, 8'h00, 1, 1, 9'd257, 1, 0, 3};
    tbl[17] = '{0, 8'h00, 0, 0, 9'd0,   0, 1, 4};

    // Reset state
    #12;
    chk("rst_bc_ready", bc_ready, 1);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_retired", retired, 0);
    chk("rst_uop_addr", uop_addr, 0);
    chk("rst_uop_last", uop_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table: basic chain, single-step + back-to-back, backpressure
    for (int i = 0; i < 18; i++) begin
      bc_valid  = tbl[i].bv;
      bc_opcode = tbl[i].op;
      uop_ready = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_uop_valid", uop_valid, tbl[i].uv);
      chk("tbl_bc_ready", bc_ready, tbl[i].bcr);
      chk("tbl_retired", retired, tbl[i].ret);
      if (tbl[i].uv) begin
        chk("tbl_uop_addr", uop_addr, tbl[i].addr);
        chk("tbl_uop_last", uop_last, tbl[i].last);
      end
      @(posedge clk); #1;
    end

    // Illegal target
    rom_mem[89] = 9'd5;
    bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b1;
    @(posedge clk); #1;
    bc_valid = 1'b0;
    @(negedge clk);
    chk("ill_uop_addr", uop_addr, 89);
    chk("ill_uop_last", uop_last, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_err_code", err_code, 2'b01);
    chk("ill_uop_valid", uop_valid, 0);
    chk("ill_bc_ready", bc_ready, 0);
    chk("ill_retired", retired, 4);
    @(posedge clk); #1;
    chk("ill_err_held", err, 1);
    chk("ill_cur_held", uop_addr, 89);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_code", err_code, 0);
    chk("clr_bc_ready", bc_ready, 1);
    chk("clr_busy", busy, 0);
    rom_mem[89] = 9'd256;

    // Chain of exactly MS uops retires; MS+1 overflows
    exp_ret = 4;
    rom_mem[16] = 9'd300; rom_mem[300] = 9'd301; rom_mem[301] = 9'd302; rom_mem[302] = 9'd0;
    rom_mem[17] = 9'd310; rom_mem[310] = 9'd311; rom_mem[311] = 9'd312; rom_mem[312] = 9'd313;
    ref_walk(8'h10); run_txn(8'h10, 1'b0); compare_txn();
    ref_walk(8'h11); run_txn(8'h11, 1'b0); compare_txn();
    chk("ovf_len_main", obs_addr.size(), MS);
    chk("ovf_code_main", obs_code, 2'b10);

    // Reset mid-chain
    bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b1;
    @(posedge clk); #1;
    bc_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_addr", uop_addr, 256);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_uop_valid", uop_valid, 0);
    chk("mid_retired", retired, 0);
    chk("mid_bc_ready", bc_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Restart; dut2 (MAX_STEPS=2) overflows on the same chain
    bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b1;
    @(posedge clk); #1;
    bc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rs_uop_valid", uop_valid, 1);
      chk("rs_uop_addr", uop_addr, exp_a[k]);
      chk("rs_uop_last", uop_last, k == 2);
      if (k < 2) begin
        chk("ovf2_uop_valid", uop_valid2, 1);
        chk("ovf2_uop_addr", uop_addr2, exp_a[k]);
      end else begin
        chk("ovf2_err", err2, 1);
        chk("ovf2_code", err_code2, 2'b10);
        chk("ovf2_uop_valid", uop_valid2, 0);
        chk("ovf2_retired", retired2, 0);
      end
      @(posedge clk); #1;
    end
    chk("rs_retired", retired, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Randomized chains against the reference model
    for (int a = 0; a < 512; a++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25)      rom_mem[a] = 9'd0;
      else if (r < 82) rom_mem[a] = 9'($urandom_range(256, 510));
      else if (r < 92) rom_mem[a] = 9'($urandom_range(1, 255));
      else             rom_mem[a] = 9'h1FF;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      op = 8'($urandom_range(0, 255));
      ref_walk(op);
      run_txn(op, 1'b1);
      compare_txn();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
